// File: rtl/sram_master_pkg.sv
// Shared types and default geometry for the single-port SRAM controller.
package sram_master_pkg;

    localparam int DEF_ADDRWIDTH = 4;
    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_SIZE      = 1 << DEF_ADDRWIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAPT = 3'd3,
        TURN    = 3'd4
    } state_t;

    // Only the WRITE state may put data onto the shared RAM bus.
    function automatic logic drives_bus(state_t s);
        return (s == WRITE);
    endfunction

endpackage

// File: rtl/sram_master_if.sv
// Request/response handshake plus RAM strobes; the shared data bus stays a plain inout port.
interface sram_master_if
    import sram_master_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDRWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DATAWIDTH-1:0] rsp_rdata;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic                 ram_cs;
    logic                 ram_we;
    logic                 ram_oe;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_addr, ram_cs, ram_we, ram_oe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_addr, ram_cs, ram_we, ram_oe
    );

endinterface

// File: rtl/sram_io_buf.sv
// Tristate pad driver for the shared RAM data bus.
module sram_io_buf
    import sram_master_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 oe_drive,
    input  logic [DATAWIDTH-1:0] dout,
    output logic [DATAWIDTH-1:0] din,
    inout  wire  [DATAWIDTH-1:0] pad
);

    assign pad = oe_drive ? dout : {DATAWIDTH{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_master.sv
// Single-port asynchronous SRAM controller: 2-cycle writes, 4-cycle reads with a bus turnaround.
module sram_master
    import sram_master_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int SIZE      = DEF_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_master_if.master        bus,
    inout  wire  [DATAWIDTH-1:0] ram_data
);

    if (SIZE != (1 << ADDRWIDTH)) begin : g_size_check
        $error("sram_master: SIZE must equal 2**ADDRWIDTH");
    end

    state_t               state;
    state_t               next_state;
    logic                 accept;
    logic                 cs_next;
    logic                 we_next;
    logic                 oe_next;
    logic                 drive_next;
    logic                 drive_en;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [DATAWIDTH-1:0] rd_data;

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = bus.req_we ? WRITE : RD_ADDR;
            WRITE:   next_state = IDLE;
            RD_ADDR: next_state = RD_CAPT;
            RD_CAPT: next_state = TURN;
            TURN:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so the registered copies line up with it.
    always_comb begin
        cs_next    = 1'b0;
        we_next    = 1'b0;
        oe_next    = 1'b0;
        drive_next = drives_bus(next_state);
        unique case (next_state)
            WRITE: begin
                cs_next = 1'b1;
                we_next = 1'b1;
            end
            RD_ADDR, RD_CAPT: begin
                cs_next = 1'b1;
                oe_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_cs <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.ram_oe <= 1'b0;
            drive_en   <= 1'b0;
        end else begin
            bus.ram_cs <= cs_next;
            bus.ram_we <= we_next;
            bus.ram_oe <= oe_next;
            drive_en   <= drive_next;
        end
    end

    // ram_addr doubles as the latched request address and simply holds between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_addr  <= '0;
            wdata_q       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            if (accept) begin
                bus.ram_addr <= bus.req_addr;
                wdata_q      <= bus.req_wdata;
            end
            bus.rsp_valid <= (state == RD_CAPT);
            if (state == RD_CAPT) begin
                bus.rsp_rdata <= rd_data;
            end
        end
    end

    sram_io_buf #(
        .DATAWIDTH (DATAWIDTH)
    ) u_io (
        .oe_drive (drive_en),
        .dout     (wdata_q),
        .din      (rd_data),
        .pad      (ram_data)
    );

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master with an async SRAM model and a read/write scoreboard.
module tb_sram_master;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int SZ = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    wire  [DW-1:0] ram_data;
    logic [DW-1:0] ram_mem [SZ];
    logic [DW-1:0] ref_mem [SZ];
    rd_exp_t       rd_q [$];
    wr_exp_t       wr_q [$];
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;

    sram_master_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) bus ();

    sram_master #(
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .SIZE      (SZ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous-read SRAM: drives the bus while selected for reading, stores on the edge ending a write.
    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_addr] <= ram_data;
    end
    assign ram_data = (bus.ram_cs && bus.ram_oe && !bus.ram_we) ? ram_mem[bus.ram_addr] : {DW{1'bz}};

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Per-cycle bus rules plus scoreboard pops for writes and read responses.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check_output("we_oe_exclusive", 32'(bus.ram_we && bus.ram_oe), 32'h0);
            check_output("drive_only_on_we", 32'(dut.drive_en), 32'(bus.ram_we));
            if (bus.ram_we) begin
                if (wr_q.size() == 0) begin
                    check_output("unexpected_write", 32'(bus.ram_we), 32'h0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    check_output("write_addr", 32'(bus.ram_addr), 32'(w.addr));
                    check_output("write_data", 32'(ram_data), 32'(w.data));
                    check_output("write_cs", 32'(bus.ram_cs), 32'h1);
                end
            end
            if (bus.rsp_valid) begin
                if (rd_q.size() == 0) begin
                    check_output("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    check_output("read_data", 32'(bus.rsp_rdata), 32'(r.data));
                    check_output("read_latency", 32'(cyc), 32'(r.due));
                end
            end
        end
    end

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                  output int acc_cyc);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check_output("accept_timeout", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (we) begin
            ref_mem[addr] = data;
            wr_q.push_back('{addr: addr, data: data});
        end else begin
            rd_q.push_back('{data: ref_mem[addr], due: cyc + 2});
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_output("drain", 32'(rd_q.size() + wr_q.size()), 32'h0);
    endtask

    initial begin
        int a0;
        int a1;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < SZ; i++) ref_mem[i] = '0;

        // Reset values
        #12;
        check_output("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        check_output("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check_output("rst_ram_cs", 32'(bus.ram_cs), 32'h0);
        check_output("rst_ram_we", 32'(bus.ram_we), 32'h0);
        check_output("rst_ram_oe", 32'(bus.ram_oe), 32'h0);
        check_output("rst_drive", 32'(dut.drive_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write then read of the same word
        apply_stimulus(1'b1, 4'd3, 8'hA5, a0);
        apply_stimulus(1'b0, 4'd3, 8'h00, a1);
        check_output("write_to_read_spacing", 32'(a1 - a0), 32'd2);
        release_bus();
        drain();
        check_output("ram_addr_hold", 32'(bus.ram_addr), 32'h3);
        check_output("rsp_rdata_hold", 32'(bus.rsp_rdata), 32'hA5);

        // Fill every address, then read all back with valid held
        apply_stimulus(1'b1, 4'd0, 8'h5A, a0);
        for (int i = 1; i < SZ; i++) begin
            apply_stimulus(1'b1, AW'(i), DW'(i) ^ 8'h5A, a1);
            check_output("write_spacing", 32'(a1 - a0), 32'd2);
            a0 = a1;
        end
        apply_stimulus(1'b0, 4'd0, 8'h00, a1);
        a0 = a1;
        for (int i = 1; i < SZ; i++) begin
            apply_stimulus(1'b0, AW'(i), 8'h00, a1);
            check_output("read_spacing", 32'(a1 - a0), 32'd4);
            a0 = a1;
        end
        release_bus();
        drain();

        // Read followed immediately by a write to the same word
        apply_stimulus(1'b0, 4'd5, 8'h00, a0);
        apply_stimulus(1'b1, 4'd5, 8'h3C, a1);
        check_output("read_to_write_spacing", 32'(a1 - a0), 32'd4);
        apply_stimulus(1'b0, 4'd5, 8'h00, a0);
        release_bus();
        drain();

        // A request that appears and vanishes while busy must leave no trace
        apply_stimulus(1'b0, 4'd7, 8'h00, a0);
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_wdata = 8'hFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();
        apply_stimulus(1'b0, 4'd7, 8'h00, a0);
        release_bus();
        drain();

        // Reset while in RD_CAPT abandons the read
        apply_stimulus(1'b0, 4'd9, 8'h00, a0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_ram_cs", 32'(bus.ram_cs), 32'h0);
        check_output("midrst_ram_oe", 32'(bus.ram_oe), 32'h0);
        check_output("midrst_drive", 32'(dut.drive_en), 32'h0);
        check_output("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_output("midrst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check_output("midrst_req_ready", 32'(bus.req_ready), 32'h1);
        rd_q.delete();
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_output("postrst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        apply_stimulus(1'b0, 4'd9, 8'h00, a0);
        release_bus();
        drain();

        // Alternating write/read with valid held high
        apply_stimulus(1'b1, 4'd1, 8'h11, a0);
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus(1'b0, AW'(i), 8'h00, a1);
            check_output("alt_write_spacing", 32'(a1 - a0), 32'd2);
            a0 = a1;
            if (i < 3) begin
                apply_stimulus(1'b1, AW'(i + 1), DW'(8'h11 * (i + 1)), a1);
                check_output("alt_read_spacing", 32'(a1 - a0), 32'd4);
                a0 = a1;
            end
        end
        release_bus();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
